load_unit: RTL
==============

# load_unit

Memory-access stage directly downstream of the load buffer. Accepts one issued load per cycle (address, ROB index, funct3), drives the synchronous data BRAM, realigns and sign- or zero-extends the returned word, and presents the result to the common data bus for ROB writeback. A credit-guarded result FIFO absorbs CDB backpressure, because the BRAM pipeline cannot stall.

## Interface
- `ROB_IX`, default 2: ROB index MSB; the index is `ROB_IX+1` bits wide.
- `MEM_LATENCY`, default 2: fixed BRAM read latency in cycles, minimum 1.
- `clk_in`, input, 1: the single clock.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `flush_in`, input, 1: mispredict flush; synchronous.
- `lb_valid_in`, input, 1: load buffer has a load ready to issue.
- `lb_addr_in`, input, 32: byte address.
- `lb_rob_ix_in`, input, `ROB_IX+1`: ROB index of the load.
- `lb_funct3_in`, input, 3: load type.
- `lb_read_out`, output, 1: load accepted this cycle; drives the load buffer's `read_in`.
- `mem_re_out`, output, 1: BRAM read enable.
- `mem_addr_out`, output, 30: word address, equal to `lb_addr_in[31:2]`.
- `mem_rdata_in`, input, 32: BRAM read data, valid `MEM_LATENCY` cycles after `mem_re_out`.
- `cdb_valid_out`, output, 1: a load result is present.
- `cdb_data_out`, output, 32: extended load result.
- `cdb_rob_ix_out`, output, `ROB_IX+1`: ROB index of the result.
- `cdb_ready_in`, input, 1: CDB accepts the result.
- `busy_out`, output, 1: high whenever any load is in flight or the FIFO is non-empty.

## Operation
- Localparam `FIFO_DEPTH = MEM_LATENCY + 2`.
- Credits: `used = inflight + fifo_count`, where `inflight` is the number of valid stages in the tag pipeline.
- `lb_read_out = lb_valid_in && !flush_in && used < FIFO_DEPTH`.
  - Combinational.
  - No dependence on `cdb_ready_in`, so there is no combinational path from the CDB to the load buffer.
- When `lb_read_out` is high:
  - `mem_re_out = 1` and `mem_addr_out = lb_addr_in[31:2]` in the same cycle.
  - A tag `{valid, rob_ix, funct3, addr[1:0]}` enters a `MEM_LATENCY`-stage shift pipeline.
- When `lb_read_out` is low: `mem_re_out = 0`; `mem_addr_out` is don't-care.
- Extraction happens on the tail stage, combinationally from `mem_rdata_in`. `b = mem_rdata_in >> (8*addr[1:0])`.
  - `000` lb: `{{24{b[7]}}, b[7:0]}`.
  - `100` lbu: zero-extend `b[7:0]`.
  - `001` lh: halfword at `addr[1]` (`addr[0]` ignored), sign-extended.
  - `101` lhu: halfword at `addr[1]`, zero-extended.
  - `010` and all other codes: full word; `addr[1:0]` ignored.
- The extracted `{data, rob_ix}` is written into the FIFO on the same edge the tail stage is valid.
  - Overflow is impossible by construction of the credit check.
  - An overflow assertion fires in simulation.
- FIFO output is the CDB interface.
  - Pop occurs when `cdb_valid_out && cdb_ready_in`.
  - Data and ROB index are stable while `cdb_valid_out` is high and `cdb_ready_in` is low.
- `flush_in`:
  - Clears every tag-pipeline valid bit and empties the FIFO on that edge.
  - Accepts nothing in that cycle.
  - BRAM data returning for killed tags is discarded.
- `rst_n_in` low, asynchronously:
  - Clears all valid bits and the FIFO pointers and count.
  - Holds every output at 0: `lb_read_out`, `mem_re_out`, `mem_addr_out`, `cdb_valid_out`, `cdb_data_out`, `cdb_rob_ix_out`, `busy_out`.
  - Reset mid-operation drops all loads silently.

## Timing
- Accept in cycle T, with the FIFO empty and `cdb_ready_in` high: `cdb_valid_out` is high in cycle T+`MEM_LATENCY`+1. Load-to-CDB latency is `MEM_LATENCY`+1.
- Throughput is one load per cycle, sustained indefinitely while `cdb_ready_in` stays high.
- With `cdb_ready_in` held low, exactly `FIFO_DEPTH` loads are accepted. `lb_read_out` then stays low until a pop.
- A pop in cycle C frees a credit visible in cycle C+1; the credit count is registered.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `FIFO_DEPTH` need not be a power of two.
- Flush in the same cycle as `lb_valid_in`: nothing is accepted. The next cycle has full credit.

## Structure
- `types.svh` holds:
  - `LoadFunct3` enum: `LB=000, LH=001, LW=010, LBU=100, LHU=101`.
  - A `load_extract(word, funct3, offset)` function.
- Sub-module `load_result_fifo`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Synchronous FIFO with push/pop, `count`, and `clear` inputs, and the same asynchronous active-low reset.
- Top level holds the tag pipeline, the credit logic and the extraction.

## Test plan
- Reset with `rst_n_in` low mid-stream, 3 loads in flight -> all outputs 0 asynchronously; after release, `busy_out=0` and no stale CDB result appears.
- `MEM_LATENCY=2`, memory word `0x80F0_7F01`:
  - lb @+3 -> `0xFFFF_FF80`.
  - lbu @+3 -> `0x0000_0080`.
  - lh @+2 -> `0xFFFF_80F0`.
  - lhu @+0 -> `0x0000_7F01`.
  - lw -> `0x80F0_7F01`.
- Back-to-back 8 loads with ROB indices 0..7 and `cdb_ready_in=1` -> 8 results in order, one per cycle, first at accept+3.
- `cdb_ready_in=0` with `lb_valid_in=1` continuously -> exactly 4 accepts, then `lb_read_out=0`. The head result stays stable. Raising ready drains the 4 results in order and re-enables accepts.
- Flush with 2 loads in flight and 1 in the FIFO -> no CDB output follows; a new load accepted the next cycle returns correctly at +3.

Source files
------------

// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared load-type encodings and the load data extraction helper.
//   load_funct3_e : RISC-V load funct3 codes (LB, LH, LW, LBU, LHU)
//   load_extract  : realigns a BRAM word by byte offset and sign/zero-extends
package load_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    // Unknown funct3 codes fall through to a full-word load.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  offset
    );
        logic [31:0] b;
        logic [15:0] h;
        b = word >> {offset, 3'b000};
        h = offset[1] ? word[31:16] : word[15:0];
        return funct3 == LB  ? {{24{b[7]}}, b[7:0]} :
               funct3 == LBU ? {24'h0, b[7:0]} :
               funct3 == LH  ? {{16{h[15]}}, h} :
               funct3 == LHU ? {16'h0, h} : word;
    endfunction

endpackage

// File: rtl/load_result_fifo.sv
// load_result_fifo: synchronous FIFO holding extracted load results for the CDB.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous flush, empties the FIFO (wins over push/pop)
//   push/wdata : write one entry
//   pop        : remove the head entry (ignored when empty)
//   rdata      : head entry, meaningful only while count != 0
//   count      : number of stored entries
module load_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic             do_pop;

    assign do_pop = pop && count != '0;
    assign rdata  = mem[rd];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (clear) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            assert (!(push && !do_pop && count == CW'(DEPTH)));
            if (push)
                wr <= (wr == PW'(DEPTH - 1)) ? '0 : wr + PW'(1);
            if (do_pop)
                rd <= (rd == PW'(DEPTH - 1)) ? '0 : rd + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr] <= wdata;
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: memory-access stage after the load buffer; issues BRAM reads,
// extracts/extends the returned data and hands results to the CDB through a
// credit-guarded FIFO so the non-stallable BRAM pipeline never overflows.
//   clk_in, rst_n_in, flush_in      : clock, async active-low reset, sync flush
//   lb_valid_in/addr/rob_ix/funct3  : load offered by the load buffer
//   lb_read_out                     : load accepted this cycle
//   mem_re_out, mem_addr_out        : BRAM read request (word address)
//   mem_rdata_in                    : BRAM data, MEM_LATENCY cycles after request
//   cdb_valid/data/rob_ix_out       : result towards the common data bus
//   cdb_ready_in                    : CDB accepts the result
//   busy_out                        : loads in flight or results pending
module load_unit
    import load_unit_pkg::*;
#(
    parameter int ROB_IX      = 2,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              flush_in,
    input  logic              lb_valid_in,
    input  logic [31:0]       lb_addr_in,
    input  logic [ROB_IX:0]   lb_rob_ix_in,
    input  logic [2:0]        lb_funct3_in,
    output logic              lb_read_out,
    output logic              mem_re_out,
    output logic [29:0]       mem_addr_out,
    input  logic [31:0]       mem_rdata_in,
    output logic              cdb_valid_out,
    output logic [31:0]       cdb_data_out,
    output logic [ROB_IX:0]   cdb_rob_ix_out,
    input  logic              cdb_ready_in,
    output logic              busy_out
);

    localparam int FIFO_DEPTH = MEM_LATENCY + 2;
    localparam int W          = 32 + ROB_IX + 1;
    localparam int T          = MEM_LATENCY - 1;

    logic [MEM_LATENCY-1:0]            tag_valid;
    logic [ROB_IX:0]                   tag_rob [MEM_LATENCY];
    logic [2:0]                        tag_f3  [MEM_LATENCY];
    logic [1:0]                        tag_off [MEM_LATENCY];
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
    logic [W-1:0]                      fifo_rdata;
    logic [W-1:0]                      fifo_wdata;
    logic                              pop;
    int                                used;

    // Credits come only from registered state, keeping the CDB ready signal
    // out of the combinational path back to the load buffer.
    always_comb begin
        used = $countones(tag_valid) + int'(fifo_count);
    end

    assign lb_read_out  = rst_n_in && lb_valid_in && !flush_in && used < FIFO_DEPTH;
    assign mem_re_out   = lb_read_out;
    assign mem_addr_out = lb_read_out ? lb_addr_in[31:2] : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            tag_valid <= '0;
        else if (flush_in)
            tag_valid <= '0;
        else begin
            tag_valid[0] <= lb_read_out;
            for (int i = 1; i < MEM_LATENCY; i++)
                tag_valid[i] <= tag_valid[i-1];
        end
    end

    // Payload is only looked at alongside its valid bit, so it needs no reset.
    always_ff @(posedge clk_in) begin
        tag_rob[0] <= lb_rob_ix_in;
        tag_f3[0]  <= lb_funct3_in;
        tag_off[0] <= lb_addr_in[1:0];
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_rob[i] <= tag_rob[i-1];
            tag_f3[i]  <= tag_f3[i-1];
            tag_off[i] <= tag_off[i-1];
        end
    end

    assign fifo_wdata = {load_extract(mem_rdata_in, tag_f3[T], tag_off[T]), tag_rob[T]};
    assign pop        = cdb_valid_out && cdb_ready_in;

    load_result_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .clear (flush_in),
        .push  (tag_valid[T]),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // Gating on valid keeps the outputs at zero in reset and when empty.
    assign cdb_valid_out  = fifo_count != '0;
    assign cdb_data_out   = cdb_valid_out ? fifo_rdata[W-1:ROB_IX+1] : '0;
    assign cdb_rob_ix_out = cdb_valid_out ? fifo_rdata[ROB_IX:0] : '0;
    assign busy_out       = tag_valid != '0 || fifo_count != '0;

endmodule
